// File: rtl/hazard_seq_ctrl_if.sv
// Decode-side hazard inputs and pipeline-register control outputs of hazard_seq_ctrl.
// The controller takes the slave modport; the core/datapath side takes master.
interface hazard_seq_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       id_halt;
    logic       ex_memr;
    logic [4:0] ex_rd;
    logic       ex_redirect;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_write;
    logic       id_ex_flush;
    logic       load_stall;
    logic       halted;
    logic [1:0] state;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_halt,
               ex_memr, ex_rd, ex_redirect,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               load_stall, halted, state
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_halt,
               ex_memr, ex_rd, ex_redirect,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               load_stall, halted, state
    );
endinterface

// File: rtl/hazard_seq_ctrl.sv
// Pipeline hazard/sequencing controller: load-use stall, redirect flush, warm-up and halt drain.
// Optional HAZARD_PERF_CNT_EN adds stall_cycles/flush_cycles perf counters.
//
// state | meaning
// INIT  | post-reset bubbles, fetch held off for INIT_CYCLES
// RUN   | normal operation with redirect / load-use / halt handling
// DRAIN | halt instruction in flight, bubbles for DRAIN_CYCLES
// HALT  | pipeline frozen until reset
module hazard_seq_ctrl #(
    parameter int INIT_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_cycles,
`endif
    hazard_seq_ctrl_if.slave     hz
);
    localparam int TW = 16;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t          cur_st, next_st;
    logic [TW-1:0]   init_cnt, drain_cnt;
    logic            load_use;
    logic            pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic            load_stall, halted;

    assign load_use = hz.ex_memr && (hz.ex_rd != 5'd0) &&
                      ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_st    <= INIT;
            init_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            cur_st    <= next_st;
            init_cnt  <= (cur_st == INIT)  ? init_cnt + 1'b1  : '0;
            // Leaving RUN via halt always lands with drain_cnt already cleared.
            drain_cnt <= (cur_st == DRAIN) ? drain_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        next_st     = cur_st;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_write = 1'b0;
        id_ex_flush = 1'b0;
        load_stall  = 1'b0;
        halted      = 1'b0;
        case (cur_st)
            INIT: begin
                if_id_write = 1'b1;
                if_id_flush = 1'b1;
                id_ex_write = 1'b1;
                id_ex_flush = 1'b1;
                if (init_cnt == TW'(INIT_CYCLES - 1))
                    next_st = RUN;
            end
            RUN: begin
                if (hz.ex_redirect) begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_write = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    id_ex_write = 1'b1;
                    id_ex_flush = 1'b1;
                    load_stall  = 1'b1;
                end else if (hz.id_halt) begin
                    if_id_write = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_write = 1'b1;
                    next_st     = DRAIN;
                end else begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    id_ex_write = 1'b1;
                end
            end
            DRAIN: begin
                if_id_write = 1'b1;
                if_id_flush = 1'b1;
                id_ex_write = 1'b1;
                id_ex_flush = 1'b1;
                if (drain_cnt == TW'(DRAIN_CYCLES - 1))
                    next_st = HALT;
            end
            default: begin
                halted = 1'b1;
            end
        endcase
    end

    assign hz.pc_write    = pc_write;
    assign hz.if_id_write = if_id_write;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_write = id_ex_write;
    assign hz.id_ex_flush = id_ex_flush;
    assign hz.load_stall  = load_stall;
    assign hz.halted      = halted;
    assign hz.state       = cur_st;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (load_stall)
                stall_cycles <= stall_cycles + 1'b1;
            if ((cur_st == RUN) && hz.ex_redirect)
                flush_cycles <= flush_cycles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_seq_ctrl.sv
// Directed-vector bench for hazard_seq_ctrl with hand-computed expected outputs.
module tb_hazard_seq_ctrl;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    hazard_seq_ctrl_if hz();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    hazard_seq_ctrl #(.INIT_CYCLES(2), .DRAIN_CYCLES(3), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles),
`endif
        .hz           (hz.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Expected vector order: pc_write if_id_write if_id_flush id_ex_write id_ex_flush load_stall halted
    task automatic chk_out(input string tag, input logic [6:0] exp_v, input logic [1:0] exp_st);
        chk({tag, ".ctl"}, {25'd0, hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_write,
                             hz.id_ex_flush, hz.load_stall, hz.halted}, {25'd0, exp_v});
        chk({tag, ".state"}, {30'd0, hz.state}, {30'd0, exp_st});
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic halt, input logic memr,
                         input logic [4:0] rd, input logic redir);
        hz.id_rs1 = rs1;  hz.id_rs2 = rs2;  hz.id_uses_rs1 = u1;  hz.id_uses_rs2 = u2;
        hz.id_halt = halt; hz.ex_memr = memr; hz.ex_rd = rd;      hz.ex_redirect = redir;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    localparam logic [6:0] O_INIT  = 7'b0111100;
    localparam logic [6:0] O_RUN   = 7'b1101000;
    localparam logic [6:0] O_STALL = 7'b0001110;
    localparam logic [6:0] O_REDIR = 7'b1111100;
    localparam logic [6:0] O_HTRAN = 7'b0111000;
    localparam logic [6:0] O_DRAIN = 7'b0111100;
    localparam logic [6:0] O_HALT  = 7'b0000001;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk_out("reset", O_INIT, 2'd0);
        #9 reset = 1'b0;              // released at t=12, between edges
        #1;
        chk_out("init0", O_INIT, 2'd0);
        next_cyc; #1;
        chk_out("init1", O_INIT, 2'd0);
        next_cyc; #1;
        chk_out("run_first", O_RUN, 2'd1);

        // load-use through rs2, then the bubble in EX releases it
        drive(0, 5, 0, 1, 0, 1, 5, 0); #1;
        chk_out("lu_rs2", O_STALL, 2'd1);
        next_cyc; drive(0, 5, 0, 1, 0, 0, 0, 0); #1;
        chk_out("lu_after", O_RUN, 2'd1);
        next_cyc; drive(0, 0, 0, 1, 0, 1, 0, 0); #1;
        chk_out("lu_x0", O_RUN, 2'd1);
        next_cyc; drive(7, 0, 1, 0, 0, 1, 7, 0); #1;
        chk_out("lu_rs1", O_STALL, 2'd1);
        next_cyc; drive(7, 0, 0, 0, 0, 1, 7, 0); #1;
        chk_out("lu_rs1_unused", O_RUN, 2'd1);
        next_cyc; drive(3, 9, 0, 1, 0, 1, 3, 0); #1;
        chk_out("lu_rs2_mismatch", O_RUN, 2'd1);
        next_cyc; drive(12, 0, 1, 0, 0, 1, 12, 0); #1;
        chk_out("lu_rs1_b", O_STALL, 2'd1);

        // redirect beats load-use, then plain redirect
        next_cyc; drive(0, 5, 0, 1, 0, 1, 5, 1); #1;
        chk_out("redir_lu", O_REDIR, 2'd1);
        next_cyc; drive(0, 0, 0, 0, 1, 0, 0, 1); #1;
        chk_out("redir_halt", O_REDIR, 2'd1);

        // halt masked by load-use, stays in RUN
        next_cyc; drive(4, 0, 1, 0, 1, 1, 4, 0); #1;
        chk_out("halt_lu", O_STALL, 2'd1);
        next_cyc; drive(4, 0, 1, 0, 1, 0, 0, 0); #1;
        chk_out("halt_tran", O_HTRAN, 2'd1);
        next_cyc; drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk_out("drain0", O_DRAIN, 2'd2);
        next_cyc; drive(1, 0, 1, 0, 1, 1, 1, 1); #1;
        chk_out("drain1_redir", O_DRAIN, 2'd2);
        next_cyc; drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk_out("drain2", O_DRAIN, 2'd2);
        for (int i = 0; i < 12; i++) begin
            next_cyc;
            if (i == 4) drive(0, 0, 0, 0, 1, 0, 0, 1);
            if (i == 5) drive(2, 0, 1, 0, 0, 1, 2, 0);
            #1;
            chk_out($sformatf("halt%0d", i), O_HALT, 2'd3);
        end
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall", stall_cycles, 32'd4);
        chk("perf_flush", flush_cycles, 32'd2);
`endif

        // restart, then abandon a drain with an asynchronous reset
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1; #1;
        chk_out("reset2", O_INIT, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall_rst", stall_cycles, 32'd0);
        chk("perf_flush_rst", flush_cycles, 32'd0);
`endif
        next_cyc; reset = 1'b0; #1;
        chk_out("init0_b", O_INIT, 2'd0);
        next_cyc; #1;
        chk_out("init1_b", O_INIT, 2'd0);
        next_cyc; drive(0, 0, 0, 0, 1, 0, 0, 0); #1;
        chk_out("halt_tran_b", O_HTRAN, 2'd1);
        next_cyc; drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk_out("drain0_b", O_DRAIN, 2'd2);
        #1 reset = 1'b1; #1;
        chk_out("async_rst", O_INIT, 2'd0);
        #2 reset = 1'b0;
        next_cyc; #1;
        chk_out("init1_c", O_INIT, 2'd0);
        next_cyc; #1;
        chk_out("run_c", O_RUN, 2'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_seq_ctrl.md
Name: hazard_seq_ctrl

Overview:
- Control-side driver for the IF/ID and ID/EX pipeline registers of the 5-stage RV32 core. Generates their write-enables and flushes, plus the PC write-enable.
- Detects load-use hazards and EX-stage redirects (taken branch or jump).
- Sequences a post-reset warm-up and an ECALL/EBREAK drain-to-halt.
- Sits between the ID/EX-stage decode outputs and the IF/ID, ID/EX and PC registers.

Parameters:
INIT_CYCLES, 2, bubble cycles after reset release before fetch starts (>=1)
DRAIN_CYCLES, 3, bubble cycles after halt instruction enters EX before halted asserts (>=1)
CNT_W, 32, width of perf counters (PERF_CNT_EN only)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
id_halt  in  1  ID instruction is ECALL/EBREAK
ex_memr  in  1  instruction in EX is a load
ex_rd  in  5  destination register of instruction in EX
ex_redirect  in  1  EX resolved taken branch or jump; PC mux selects target
pc_write  out  1  PC register load enable
if_id_write  out  1  IF/ID write enable
if_id_flush  out  1  IF/ID flush (zero) request
id_ex_write  out  1  ID/EX write enable
id_ex_flush  out  1  ID/EX flush (bubble) request
load_stall  out  1  load-use stall active this cycle
halted  out  1  pipeline drained and frozen
state  out  2  FSM state: 0 INIT, 1 RUN, 2 DRAIN, 3 HALT

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk. Reset forces state=INIT and counters to 0.
- Outputs are combinational from state and inputs. State and counters are registered on the rising edge of clk.
- Invariant: any flush output high implies the matching write output high, because the pipeline registers only honour a flush while write-enabled.
- Reset-time output values (INIT): pc_write=0, if_id_write=1, if_id_flush=1, id_ex_write=1, id_ex_flush=1, load_stall=0, halted=0.
- INIT:
  - Outputs as above.
  - Internal counter init_cnt increments each cycle.
  - On init_cnt==INIT_CYCLES-1, go to RUN.
  - First PC increment occurs in the first RUN cycle.
- RUN, priority order:
  - 1) ex_redirect=1: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_write=1, id_ex_flush=1. Load-use and id_halt are ignored, since the ID instruction is squashed. Stay in RUN.
  - 2) load_use: condition is ex_memr && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
    - Response: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_flush=1, load_stall=1.
    - Exactly one bubble results, because the next cycle EX holds the bubble (ex_memr=0).
    - id_halt is ignored this cycle; it is re-evaluated when the instruction is re-presented.
  - 3) id_halt=1: pc_write=0, if_id_write=1, if_id_flush=1, id_ex_write=1, id_ex_flush=0. The halt instruction advances into EX. Go to DRAIN and clear drain_cnt.
  - 4) Otherwise: pc_write=1, if_id_write=1, id_ex_write=1, both flushes 0.
- DRAIN:
  - Outputs: pc_write=0, if_id_write=1, if_id_flush=1, id_ex_write=1, id_ex_flush=1.
  - ex_redirect, id_halt and load-use are ignored. No instruction older than the halt remains in EX.
  - drain_cnt increments; on drain_cnt==DRAIN_CYCLES-1, go to HALT.
- HALT:
  - pc_write=0, if_id_write=0, id_ex_write=0, flushes 0, halted=1.
  - Only reset exits HALT.
- Reset asserted in any state returns to INIT immediately (asynchronously); any in-progress drain is abandoned.
- Register x0: ex_rd==0 never causes a stall.

Optional Feature:
Macro: HAZARD_PERF_CNT_EN
- Defined:
  - Adds outputs stall_cycles[CNT_W] and flush_cycles[CNT_W], both reset to 0.
  - stall_cycles increments on every cycle with load_stall=1.
  - flush_cycles increments on every RUN cycle with ex_redirect=1.
  - Both counters wrap modulo 2^CNT_W and freeze in HALT.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, INIT_CYCLES=2 -> cycles 0-1: state=0, pc_write=0, both flushes=1; cycle 2: state=1, pc_write=1.
- RUN, ex_memr=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1, load_stall=1. Next cycle (ex_memr=0): normal advance. Repeat with ex_rd=0 -> no stall.
- Load-use condition and ex_redirect=1 in the same cycle -> redirect wins: pc_write=1, both flushes=1, load_stall=0.
- id_halt=1 in RUN, DRAIN_CYCLES=3 -> transition cycle with id_ex_flush=0; 3 DRAIN cycles with both flushes=1; then halted=1, all writes 0, held for 10+ cycles. ex_redirect pulse in DRAIN has no effect.
- reset asserted mid-DRAIN (asynchronously, between clock edges) -> state=0 and pc_write=0 immediately; INIT sequence repeats.
- HAZARD_PERF_CNT_EN: 4 load-use stalls and 2 redirects -> stall_cycles=4, flush_cycles=2; values unchanged after halt.
